layer_priority_compositor: RTL
==============================

Name: layer_priority_compositor

Overview:
- Per-pixel compositor directly downstream of the OBJ row engine and the BG renderers.
- Each valid pixel slot it takes four BG packets and one OBJ packet, all 20 bits and aligned to the same hcount.
- It selects the top visible layer and the second visible layer, then resolves the effective colour-special-effect mode from BLDCNT.
- Outputs feed the palette lookup and blend unit through a fixed 3-stage pipeline with valid tracking.

Parameters:
- LATENCY, 3, pipeline depth in cycles; fixed, present for bench reference only.
- BD_ID, 3'd4, layer id used for the synthesized backdrop packet.

Ports:
- clock  input  1  system clock
- reset  input  1  reset
- line_start  input  1  flushes all in-flight pixels (new scanline)
- pix_valid  input  1  input packets valid this cycle
- hcount_in  input  8  column of input pixel
- bg0_packet, bg1_packet, bg2_packet, bg3_packet  input  20 each  BG layer packets
- obj_packet  input  20  OBJ packet from the OBJ row buffer
- dispcnt  input  16  DISPCNT MMIO
- bldcnt  input  16  BLDCNT MMIO
- out_valid  output  1  outputs valid
- out_hcount  output  8  column of output pixel
- top_packet  output  20  winning layer packet
- second_packet  output  20  runner-up layer packet
- blend_mode  output  2  0 none, 1 alpha, 2 brighten, 3 darken

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clock.
- Packet format (shared):
  - [19:18] priority
  - [17:15] layer id (0-3 BG, 4 backdrop, 5 OBJ)
  - [14:13] objmode
  - [12] transparent
  - [11:9] reserved 0
  - [8] palettemode
  - [7:0] palette index
- Reset: all pipeline registers 0; out_valid=0, out_hcount=0, top_packet=0, second_packet=0, blend_mode=0.
- Stage 1 (register inputs + mask):
  - BGi candidate = ~transparent & dispcnt[8+i].
  - OBJ candidate = ~transparent & dispcnt[12] & objmode!=2 (window objects never drawn).
  - dispcnt[7] forced blank: no candidates.
  - Latches bldcnt and dispcnt at this stage; MMIO changes take effect per pixel.
- Stage 2 (sort):
  - Lower priority value wins.
  - Tie: OBJ beats any BG; among BGs the lower index wins.
  - top = best candidate; second = best remaining candidate.
  - Missing slot is filled with the backdrop packet {2'd3, BD_ID, 2'd0, 1'b0, 3'd0, 1'b0, 8'd0}.
- Stage 3 (effect):
  - first-target bit = bldcnt[id], second-target bit = bldcnt[8+id]; OBJ id maps to bit 4, backdrop to bit 5.
  - If top is OBJ with objmode==1 and second is a second target: blend_mode=1, overriding bldcnt[7:6].
  - Else if bldcnt[7:6]==1: requires top first target and second second target, else 0.
  - Else if bldcnt[7:6] in {2,3}: requires top first target, else 0.
  - Else 0.
- Latency: pix_valid at cycle N gives out_valid at N+3 with the matching hcount. Throughput is 1 pixel/cycle, no backpressure.
- line_start: synchronously clears all stage valids in the same edge. A pixel presented with line_start=1 is captured as stage-1 valid (the new line's first pixel). out_valid stays 0 for the flushed slots.
- Non-valid slots still shift; their data is don't-care but blend_mode is forced 0 when the slot is invalid.
- Reset mid-line: immediate async clear, no output until new pix_valid+3.

Decomposition:
- Shared package gfx_pkg holds:
  - packet field offsets
  - layer id constants (BG0..BG3=0..3, BD=4, OBJ=5)
  - blend mode enum {BLEND_NONE, BLEND_ALPHA, BLEND_BRIGHT, BLEND_DARK}
  - objmode constants (NORMAL=0, SEMI=1, WINDOW=2)
  - backdrop packet constant
- One sub-module: layer_sort_unit (combinational; 5 candidates -> top/second), instantiated in stage 2.

Test Plan:
1. Single layer: BG2 pri1 opaque, others transparent, dispcnt=0x0400, bldcnt=0 -> after 3 cycles top id=2, second = backdrop packet, blend_mode=0.
2. Tie: OBJ pri2 and BG0 pri2 both opaque, dispcnt=0x1100 -> top id=5, second id=0. Then BG0 pri1 -> top id=0, second id=5.
3. Semi-transparent OBJ: OBJ objmode=1 pri0, BG1 pri3, bldcnt=0x0200 (BG1 second target, mode 0) -> blend_mode=1. With bldcnt=0 -> blend_mode=0.
4. Brighten/darken: BG0 top, bldcnt=0x0081 -> blend_mode=2. bldcnt=0x00C2 (BG1 first only) -> blend_mode=0.
5. Forced blank and window OBJ: dispcnt[7]=1 -> top and second both backdrop. OBJ objmode=2 is never selected.
6. Flush/reset: stream hcount 0..9, assert line_start at hcount 5 -> outputs for 3,4 suppressed, 5 emitted. Async reset mid-stream -> out_valid=0 immediately, resumes 3 cycles after next pix_valid.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared graphics-pipeline definitions: packet layout, layer ids, object modes
// and colour-special-effect modes used by the compositor and its sort unit.
package gfx_pkg;

    localparam int unsigned PKT_W          = 20;
    localparam int unsigned PKT_PRI_HI     = 19;
    localparam int unsigned PKT_PRI_LO     = 18;
    localparam int unsigned PKT_ID_HI      = 17;
    localparam int unsigned PKT_ID_LO      = 15;
    localparam int unsigned PKT_OBJMODE_HI = 14;
    localparam int unsigned PKT_OBJMODE_LO = 13;
    localparam int unsigned PKT_TRANSP     = 12;
    localparam int unsigned PKT_PALMODE    = 8;
    localparam int unsigned PKT_INDEX_HI   = 7;
    localparam int unsigned PKT_INDEX_LO   = 0;

    localparam int unsigned NUM_SLOTS = 5;
    localparam int unsigned SLOT_OBJ  = 4;

    localparam logic [2:0] LAYER_BG0 = 3'd0;
    localparam logic [2:0] LAYER_BG1 = 3'd1;
    localparam logic [2:0] LAYER_BG2 = 3'd2;
    localparam logic [2:0] LAYER_BG3 = 3'd3;
    localparam logic [2:0] LAYER_BD  = 3'd4;
    localparam logic [2:0] LAYER_OBJ = 3'd5;

    localparam logic [1:0] OBJMODE_NORMAL = 2'd0;
    localparam logic [1:0] OBJMODE_SEMI   = 2'd1;
    localparam logic [1:0] OBJMODE_WINDOW = 2'd2;

    typedef enum logic [1:0] {
        BLEND_NONE   = 2'd0,
        BLEND_ALPHA  = 2'd1,
        BLEND_BRIGHT = 2'd2,
        BLEND_DARK   = 2'd3
    } blend_mode_t;

    localparam logic [PKT_W-1:0] BACKDROP_PACKET =
        {2'd3, LAYER_BD, OBJMODE_NORMAL, 1'b0, 3'd0, 1'b0, 8'd0};

    function automatic logic [1:0] pkt_priority(input logic [PKT_W-1:0] pkt);
        return pkt[PKT_PRI_HI:PKT_PRI_LO];
    endfunction

    function automatic logic [2:0] pkt_layer(input logic [PKT_W-1:0] pkt);
        return pkt[PKT_ID_HI:PKT_ID_LO];
    endfunction

    function automatic logic [1:0] pkt_objmode(input logic [PKT_W-1:0] pkt);
        return pkt[PKT_OBJMODE_HI:PKT_OBJMODE_LO];
    endfunction

endpackage

// File: rtl/layer_sort_unit.sv
// Combinational two-deep selection over the five layer slots (BG0..BG3, OBJ):
// returns the best and runner-up candidates, backdrop-filled when missing.
module layer_sort_unit
    import gfx_pkg::*;
#(
    parameter logic [PKT_W-1:0] BACKDROP = BACKDROP_PACKET
) (
    input  logic [NUM_SLOTS-1:0][PKT_W-1:0] slot_pkt,
    input  logic [NUM_SLOTS-1:0]            slot_cand,
    output logic [PKT_W-1:0]                top_packet,
    output logic [PKT_W-1:0]                second_packet
);

    // Rank = {priority, tiebreak}; OBJ gets tiebreak 0, BGi gets i+1, so ranks are unique.
    function automatic logic [4:0] rank(input logic [PKT_W-1:0] pkt, input int unsigned slot);
        return {pkt_priority(pkt), (slot == SLOT_OBJ) ? 3'd0 : 3'(slot + 1)};
    endfunction

    logic             top_found;
    logic             second_found;
    logic [2:0]       top_slot;
    logic [4:0]       top_rank;
    logic [4:0]       second_rank;
    logic [PKT_W-1:0] top_pkt;
    logic [PKT_W-1:0] second_pkt;

    always_comb begin
        top_found    = 1'b0;
        second_found = 1'b0;
        top_slot     = '0;
        top_rank     = '1;
        second_rank  = '1;
        top_pkt      = BACKDROP;
        second_pkt   = BACKDROP;

        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (slot_cand[i] && (!top_found || rank(slot_pkt[i], i) < top_rank)) begin
                top_found = 1'b1;
                top_slot  = 3'(i);
                top_rank  = rank(slot_pkt[i], i);
                top_pkt   = slot_pkt[i];
            end
        end

        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (slot_cand[i] && (3'(i) != top_slot) &&
                (!second_found || rank(slot_pkt[i], i) < second_rank)) begin
                second_found = 1'b1;
                second_rank  = rank(slot_pkt[i], i);
                second_pkt   = slot_pkt[i];
            end
        end

        top_packet    = top_pkt;
        second_packet = second_pkt;
    end

endmodule

// File: rtl/layer_priority_compositor.sv
// Per-pixel layer compositor: mask (stage 1), sort top/second (stage 2),
// resolve colour special effect (stage 3). One pixel per cycle, no backpressure.
module layer_priority_compositor
    import gfx_pkg::*;
#(
    parameter int unsigned LATENCY = 3,
    parameter logic [2:0]  BD_ID   = 3'd4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             line_start,
    input  logic             pix_valid,
    input  logic [7:0]       hcount_in,
    input  logic [PKT_W-1:0] bg0_packet,
    input  logic [PKT_W-1:0] bg1_packet,
    input  logic [PKT_W-1:0] bg2_packet,
    input  logic [PKT_W-1:0] bg3_packet,
    input  logic [PKT_W-1:0] obj_packet,
    input  logic [15:0]      dispcnt,
    input  logic [15:0]      bldcnt,
    output logic             out_valid,
    output logic [7:0]       out_hcount,
    output logic [PKT_W-1:0] top_packet,
    output logic [PKT_W-1:0] second_packet,
    output logic [1:0]       blend_mode
);

    localparam logic [PKT_W-1:0] BACKDROP = {2'd3, BD_ID, OBJMODE_NORMAL, 1'b0, 3'd0, 1'b0, 8'd0};

    logic [LATENCY-1:0]             valid_q;
    logic [LATENCY-1:0][7:0]        hcount_q;

    logic [NUM_SLOTS-1:0][PKT_W-1:0] slot_pkt;
    logic [NUM_SLOTS-1:0]            slot_cand;
    logic [NUM_SLOTS-1:0][PKT_W-1:0] pkt_s1;
    logic [NUM_SLOTS-1:0]            cand_s1;
    logic [13:0]                     bldcnt_s1;

    logic [PKT_W-1:0] sort_top;
    logic [PKT_W-1:0] sort_second;
    logic [PKT_W-1:0] top_s2;
    logic [PKT_W-1:0] second_s2;
    logic [13:0]      bldcnt_s2;

    logic        top_first;
    logic        sec_second;
    blend_mode_t blend_next;

    logic unused_mmio;
    assign unused_mmio = ^{dispcnt[15:13], dispcnt[6:0], bldcnt[15:14]};

    always_comb begin
        slot_pkt  = {obj_packet, bg3_packet, bg2_packet, bg1_packet, bg0_packet};
        slot_cand = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            slot_cand[i] = ~slot_pkt[i][PKT_TRANSP] & dispcnt[8 + i] & ~dispcnt[7];
        end
        slot_cand[SLOT_OBJ] = ~obj_packet[PKT_TRANSP] & dispcnt[12] & ~dispcnt[7] &
                              (pkt_objmode(obj_packet) != OBJMODE_WINDOW);
    end

    layer_sort_unit #(
        .BACKDROP(BACKDROP)
    ) u_sort (
        .slot_pkt      (pkt_s1),
        .slot_cand     (cand_s1),
        .top_packet    (sort_top),
        .second_packet (sort_second)
    );

    // Target-select bit for a layer id: BG0..3 -> 0..3, OBJ -> 4, backdrop -> 5.
    function automatic logic target_bit(input logic [5:0] mask, input logic [2:0] id);
        if (id <= LAYER_BG3) begin
            return mask[id[1:0]];
        end else if (id == LAYER_OBJ) begin
            return mask[4];
        end else if (id == BD_ID) begin
            return mask[5];
        end
        return 1'b0;
    endfunction

    always_comb begin
        blend_next = BLEND_NONE;
        top_first  = target_bit(bldcnt_s2[5:0], pkt_layer(top_s2));
        sec_second = target_bit(bldcnt_s2[13:8], pkt_layer(second_s2));
        if (pkt_layer(top_s2) == LAYER_OBJ && pkt_objmode(top_s2) == OBJMODE_SEMI && sec_second) begin
            blend_next = BLEND_ALPHA;
        end else begin
            case (blend_mode_t'(bldcnt_s2[7:6]))
                BLEND_ALPHA:  if (top_first && sec_second) blend_next = BLEND_ALPHA;
                BLEND_BRIGHT: if (top_first) blend_next = BLEND_BRIGHT;
                BLEND_DARK:   if (top_first) blend_next = BLEND_DARK;
                default:      blend_next = BLEND_NONE;
            endcase
        end
    end

    // line_start drops the slots moving into stages 2 and 3 but keeps the pixel arriving with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q  <= '0;
            hcount_q <= '0;
        end else begin
            valid_q[0]           <= pix_valid;
            valid_q[LATENCY-1:1] <= line_start ? '0 : valid_q[LATENCY-2:0];
            hcount_q             <= {hcount_q[LATENCY-2:0], hcount_in};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_s1        <= '0;
            cand_s1       <= '0;
            bldcnt_s1     <= '0;
            top_s2        <= '0;
            second_s2     <= '0;
            bldcnt_s2     <= '0;
            top_packet    <= '0;
            second_packet <= '0;
            blend_mode    <= BLEND_NONE;
        end else begin
            pkt_s1        <= slot_pkt;
            cand_s1       <= slot_cand;
            bldcnt_s1     <= bldcnt[13:0];
            top_s2        <= sort_top;
            second_s2     <= sort_second;
            bldcnt_s2     <= bldcnt_s1;
            top_packet    <= top_s2;
            second_packet <= second_s2;
            blend_mode    <= (valid_q[LATENCY-2] && !line_start) ? blend_next : BLEND_NONE;
        end
    end

    assign out_valid  = valid_q[LATENCY-1];
    assign out_hcount = hcount_q[LATENCY-1];

endmodule
